// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between N_REQ byte producers. Requesters are
// served round-robin; each accepted byte goes out as a framed sequence:
//    header  = HEADER_BASE | granted index
//    payload = byte latched from the granted requester
//    (checksum = header ^ payload, only when UART_TX_ARBITER_CHECKSUM_EN
//     is defined at build time)
// Each byte is handed to the TX core with a one-cycle tx_start pulse. The
// arbiter then waits for the core's tx_done pulse before moving on.
//
// Build option:
//    UART_TX_ARBITER_CHECKSUM_EN  - appends a checksum byte (3-byte frames).
//                                   Undefined: 2-byte frames, no CHK states.
//
// Parameters:
//    N_REQ        number of requesters, 2..8
//    HEADER_BASE  header byte base; its low 3 bits must be zero
//
// Ports:
//    clk        in   system clock
//    rst_n      in   asynchronous active-low reset
//    req_valid  in   [N_REQ]    per-requester byte available
//    req_data   in   [8*N_REQ]  payloads, requester i on bits [8i+7:8i]
//    req_ready  out  [N_REQ]    combinational accept strobe (valid&ready = transfer)
//    tx_data    out  [8]        byte to the UART TX core (registered)
//    tx_start   out             one-cycle start pulse to the TX core (registered)
//    tx_done    in              one-cycle pulse when the TX core finished a byte
//    busy       out             high whenever a frame is in progress
//    grant_id   out  [3]        index of the requester being serviced
//
// States:
//    state    | meaning
//    ---------+-----------------------------------------------------------
//    IDLE     | arbitrating; req_ready may be asserted for the winner
//    SEND_HDR | tx_start pulse with the header byte
//    WAIT_HDR | header shifting out, waiting for tx_done
//    SEND_DAT | tx_start pulse with the payload byte
//    WAIT_DAT | payload shifting out, waiting for tx_done
//    SEND_CHK | tx_start pulse with the checksum byte (checksum build only)
//    WAIT_CHK | checksum shifting out, waiting for tx_done (checksum build only)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int         N_REQ       = 2,
    parameter logic [7:0] HEADER_BASE = 8'hA0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_done,
    output logic               busy,
    output logic [2:0]         grant_id
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        WAIT_HDR,
        SEND_DAT,
`ifdef UART_TX_ARBITER_CHECKSUM_EN
        WAIT_DAT,
        SEND_CHK,
        WAIT_CHK
`else
        WAIT_DAT
`endif
    } state_t;

    state_t      state_q;
    logic [2:0]  rr_ptr_q;
    logic [2:0]  rr_ptr_d;
    logic [2:0]  grant_id_q;
    logic [7:0]  payload_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic        busy_q;

    // Inputs widened to the 8-requester maximum so the arbiter can index
    // them with a fixed 3-bit index regardless of N_REQ.
    logic [7:0]  valid_ext;
    logic [63:0] data_ext;

    logic        win_found;
    logic [2:0]  win_idx;
    logic [3:0]  cand;
    logic [3:0]  win_inc;
    logic [7:0]  win_data;

`ifdef UART_TX_ARBITER_CHECKSUM_EN
    logic [7:0]  hdr_byte;
    assign hdr_byte = HEADER_BASE | {5'b00000, grant_id_q};
`endif

    always_comb begin
        valid_ext = '0;
        valid_ext[N_REQ-1:0] = req_valid;
        data_ext = '0;
        data_ext[8*N_REQ-1:0] = req_data;
    end

    // Round-robin search starting at rr_ptr_q. The candidate index wraps
    // modulo N_REQ with a single subtract since rr_ptr_q < N_REQ and k < N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (!win_found && valid_ext[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        win_inc  = {1'b0, win_idx} + 4'd1;
        rr_ptr_d = (win_inc >= 4'(N_REQ)) ? 3'd0 : win_inc[2:0];
        win_data = data_ext[{win_idx, 3'b000} +: 8];
    end

    // Accept strobe: only in IDLE and only for the winner. Gated by rst_n so
    // nothing can transfer while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && win_found) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (win_idx == 3'(i)) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            payload_q  <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_start_q <= 1'b0;
                    if (win_found) begin
                        payload_q  <= win_data;
                        grant_id_q <= win_idx;
                        rr_ptr_q   <= rr_ptr_d;
                        tx_data_q  <= HEADER_BASE | {5'b00000, win_idx};
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= SEND_HDR;
                    end
                end
                SEND_HDR: begin
                    tx_start_q <= 1'b0;
                    state_q    <= WAIT_HDR;
                end
                WAIT_HDR: begin
                    if (tx_done) begin
                        tx_data_q  <= payload_q;
                        tx_start_q <= 1'b1;
                        state_q    <= SEND_DAT;
                    end
                end
                SEND_DAT: begin
                    tx_start_q <= 1'b0;
                    state_q    <= WAIT_DAT;
                end
                WAIT_DAT: begin
                    if (tx_done) begin
`ifdef UART_TX_ARBITER_CHECKSUM_EN
                        tx_data_q  <= hdr_byte ^ payload_q;
                        tx_start_q <= 1'b1;
                        state_q    <= SEND_CHK;
`else
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
`endif
                    end
                end
`ifdef UART_TX_ARBITER_CHECKSUM_EN
                SEND_CHK: begin
                    tx_start_q <= 1'b0;
                    state_q    <= WAIT_CHK;
                end
                WAIT_CHK: begin
                    if (tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    tx_start_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule
